// File: rtl/modport_dut_pkg.sv
// Shared types and constants for the modport_dut signed multiplier with parity-checked operands.
// Optional operand parity checking is enabled by defining PARITY_CHECK_EN.
package modport_dut_pkg;

  localparam int ARG_W = 16;
  localparam int RES_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [ARG_W-1:0] a;
    logic             a_parity;
    logic [ARG_W-1:0] b;
    logic             b_parity;
  } operands_t;

  typedef struct packed {
    logic [RES_W-1:0] value;
    logic             parity;
    logic             parity_error;
  } result_t;

  // Even parity: the returned bit equals the XOR of all bits of v.
  function automatic logic even_parity(input logic [RES_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/modport_dut_if.sv
// Operand/result bus of modport_dut; master drives operands and req, slave returns ack and result.
// Handshake: 4-phase. Master raises req with operands stable, slave raises ack; master drops req,
// slave drops ack; result_rdy then pulses for one cycle with result fields valid.
interface modport_dut_if;
  import modport_dut_pkg::*;

  logic signed [ARG_W-1:0] arg_a;
  logic                    arg_a_parity;
  logic signed [ARG_W-1:0] arg_b;
  logic                    arg_b_parity;
  logic                    req;
  logic                    ack;
  logic signed [RES_W-1:0] result;
  logic                    result_parity;
  logic                    result_rdy;
  logic                    arg_parity_error;

  modport master (
    output arg_a, arg_a_parity, arg_b, arg_b_parity, req,
    input  ack, result, result_parity, result_rdy, arg_parity_error
  );

  modport slave (
    input  arg_a, arg_a_parity, arg_b, arg_b_parity, req,
    output ack, result, result_parity, result_rdy, arg_parity_error
  );

endinterface

// File: rtl/modport_parity.sv
// Even-parity generator for a W-bit vector (W must not exceed RES_W).
module modport_parity
  import modport_dut_pkg::*;
#(
  parameter int W = ARG_W
) (
  input  logic [W-1:0] data,
  output logic         parity
);

  // Zero-extension leaves the XOR reduction unchanged.
  logic [RES_W-1:0] data_ext;

  assign data_ext = RES_W'(data);
  assign parity   = even_parity(data_ext);

endmodule

// File: rtl/modport_dut.sv
// Handshaked 16x16 signed multiplier: IDLE->ACK->CALC->DONE, registered 32-bit product and parity.
// Define PARITY_CHECK_EN to reject operands whose even-parity bits are wrong (result forced to 0).
module modport_dut
  import modport_dut_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  modport_dut_if.slave bus,
  output state_t       state_dbg
);

  state_t    state;
  state_t    state_next;
  operands_t ops;
  result_t   res_q;
  logic      ack_q;
  logic      rdy_q;

  logic signed [RES_W-1:0] product;
  logic [RES_W-1:0]        res_value_next;
  logic                    res_parity_next;
  logic                    a_parity_calc;
  logic                    b_parity_calc;
  logic                    parity_error_next;

  modport_parity #(.W(ARG_W)) u_a_parity (.data(ops.a), .parity(a_parity_calc));
  modport_parity #(.W(ARG_W)) u_b_parity (.data(ops.b), .parity(b_parity_calc));
  modport_parity #(.W(RES_W)) u_res_parity (.data(res_value_next), .parity(res_parity_next));

  // Both operands sign-extend to the 32-bit context, so -32768*-32768 stays exact.
  assign product = $signed(ops.a) * $signed(ops.b);

`ifdef PARITY_CHECK_EN
  assign parity_error_next = (a_parity_calc != ops.a_parity) || (b_parity_calc != ops.b_parity);
`else
  logic unused_parity_bits;
  assign unused_parity_bits = ^{a_parity_calc, b_parity_calc, ops.a_parity, ops.b_parity};
  assign parity_error_next  = 1'b0;
`endif

  assign res_value_next = parity_error_next ? '0 : product;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req)  state_next = ACK;
      ACK:     if (!bus.req) state_next = CALC;
      CALC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      ops   <= '0;
      res_q <= '0;
      ack_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_next;
      ack_q <= (state_next == ACK);
      rdy_q <= (state_next == DONE);
      if (state == IDLE && bus.req) begin
        ops <= '{a: bus.arg_a, a_parity: bus.arg_a_parity,
                 b: bus.arg_b, b_parity: bus.arg_b_parity};
      end
      if (state == CALC) begin
        res_q <= '{value: res_value_next, parity: res_parity_next,
                   parity_error: parity_error_next};
      end
    end
  end

  assign bus.ack              = ack_q;
  assign bus.result_rdy       = rdy_q;
  assign bus.result           = res_q.value;
  assign bus.result_parity    = res_q.parity;
  assign bus.arg_parity_error = res_q.parity_error;
  assign state_dbg            = state;

endmodule

// File: tb/tb_modport_dut.sv
// Directed self-checking bench for modport_dut: handshake timing, products, parity, reset aborts.
module tb_modport_dut;
  import modport_dut_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;
  int     n_checks;
  int     n_pass;

  modport_dut_if bus ();

  modport_dut dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic start_req(input logic [15:0] a, input logic ap, input logic [15:0] b,
                           input logic bp);
    @(negedge clk);
    bus.arg_a = a;
    bus.arg_a_parity = ap;
    bus.arg_b = b;
    bus.arg_b_parity = bp;
    bus.req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.ack) break;
    end
    check("ack_rise", 32'(bus.ack), 32'd1);
    check("state_ack", 32'(state_dbg), 32'(ACK));
  endtask

  // Keep req high for n more cycles while scrambling the operand bus.
  task automatic hold_ack(input int n);
    for (int i = 0; i < n; i++) begin
      bus.arg_a = 16'h1234 + 16'(i);
      bus.arg_b = 16'hBEEF;
      bus.arg_a_parity = ~bus.arg_a_parity;
      @(negedge clk);
      check("ack_held", 32'(bus.ack), 32'd1);
    end
  endtask

  task automatic finish_txn(input string tag, input logic [31:0] exp_res, input logic exp_par,
                            input logic exp_err);
    bus.req = 1'b0;
    bus.arg_a = 16'h5A5A;
    bus.arg_b = 16'h0F0F;
    @(negedge clk);
    check({tag, "_ack_drop"}, 32'(bus.ack), 32'd0);
    check({tag, "_rdy_early"}, 32'(bus.result_rdy), 32'd0);
    @(negedge clk);
    check({tag, "_rdy"}, 32'(bus.result_rdy), 32'd1);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_parity"}, 32'(bus.result_parity), 32'(exp_par));
    check({tag, "_err"}, 32'(bus.arg_parity_error), 32'(exp_err));
    @(negedge clk);
    check({tag, "_rdy_pulse"}, 32'(bus.result_rdy), 32'd0);
    check({tag, "_result_hold"}, bus.result, exp_res);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    check({tag, "_ack"}, 32'(bus.ack), 32'd0);
    check({tag, "_rdy"}, 32'(bus.result_rdy), 32'd0);
    check({tag, "_result"}, bus.result, 32'd0);
    check({tag, "_parity"}, 32'(bus.result_parity), 32'd0);
    check({tag, "_err"}, 32'(bus.arg_parity_error), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst_n = 1'b1;
    bus.req = 1'b0;
    bus.arg_a = '0;
    bus.arg_a_parity = 1'b0;
    bus.arg_b = '0;
    bus.arg_b_parity = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b0;

    start_req(16'd3, 1'b0, 16'd4, 1'b1);
    finish_txn("mul_3x4", 32'd12, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("idle_hold_result", bus.result, 32'd12);
    check("idle_no_rdy", 32'(bus.result_rdy), 32'd0);

    start_req(16'hFFFE, 1'b1, 16'd5, 1'b0);
    hold_ack(1);
    finish_txn("mul_m2x5", 32'hFFFF_FFF6, 1'b0, 1'b0);

    start_req(16'h8000, 1'b1, 16'h8000, 1'b1);
    finish_txn("mul_min_sq", 32'h4000_0000, 1'b1, 1'b0);

    start_req(16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
    hold_ack(3);
    finish_txn("mul_max_sq", 32'h3FFF_0001, 1'b1, 1'b0);

    start_req(16'd7, 1'b0, 16'd2, 1'b1);
`ifdef PARITY_CHECK_EN
    finish_txn("bad_parity", 32'd0, 1'b0, 1'b1);
`else
    finish_txn("bad_parity", 32'd14, 1'b1, 1'b0);
`endif

    // reset wins over a simultaneous request
    @(negedge clk);
    bus.arg_a = 16'd9;
    bus.arg_b = 16'd9;
    bus.req = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("rst_vs_req");
    bus.req = 1'b0;
    rst_n = 1'b0;

    // reset while in CALC aborts the transaction
    start_req(16'd5, 1'b0, 16'd3, 1'b0);
    bus.req = 1'b0;
    @(negedge clk);
    check("calc_state", 32'(state_dbg), 32'(CALC));
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("rst_in_calc");
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rdy", 32'(bus.result_rdy), 32'd0);
    end
    start_req(16'd6, 1'b0, 16'd7, 1'b1);
    finish_txn("mul_6x7", 32'd42, 1'b1, 1'b0);

    // back-to-back: second request raised early must wait for IDLE
    start_req(16'd3, 1'b0, 16'd4, 1'b1);
    hold_ack(2);
    bus.req = 1'b0;
    @(negedge clk);
    check("b2b_calc_ack", 32'(bus.ack), 32'd0);
    bus.arg_a = 16'd10;
    bus.arg_a_parity = 1'b0;
    bus.arg_b = 16'd10;
    bus.arg_b_parity = 1'b0;
    bus.req = 1'b1;
    @(negedge clk);
    check("b2b_first_rdy", 32'(bus.result_rdy), 32'd1);
    check("b2b_first_result", bus.result, 32'd12);
    check("b2b_done_no_ack", 32'(bus.ack), 32'd0);
    bus.arg_a = 16'd6;
    bus.arg_a_parity = 1'b0;
    bus.arg_b = 16'd7;
    bus.arg_b_parity = 1'b1;
    @(negedge clk);
    check("b2b_idle_state", 32'(state_dbg), 32'(IDLE));
    check("b2b_idle_no_ack", 32'(bus.ack), 32'd0);
    check("b2b_idle_no_rdy", 32'(bus.result_rdy), 32'd0);
    @(negedge clk);
    check("b2b_second_ack", 32'(bus.ack), 32'd1);
    hold_ack(1);
    finish_txn("b2b_second", 32'd42, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
